// File: rtl/pipe_controller.sv
// Control unit for the five-stage MIPS pipeline: Decode-stage decode plus D->E, E->M, M->W control registers.
// Optional sticky illegal-instruction detection is enabled by defining PIPE_CTRL_ILLEGAL_EN.
module pipe_controller #(
  parameter int ALUCW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opD,
  input  logic [5:0]       functD,
  input  logic             equalD,
  input  logic             flushE,
  output logic             pcsrcD,
  output logic             branchD,
  output logic             jumpD,
  output logic             memtoregE,
  output logic             alusrcE,
  output logic             regdstE,
  output logic             regwriteE,
  output logic [ALUCW-1:0] alucontrolE,
  output logic             memtoregM,
  output logic             regwriteM,
  output logic             memwriteM,
  output logic             memtoregW,
  output logic             regwriteW
`ifdef PIPE_CTRL_ILLEGAL_EN
  ,
  output logic             illegalF
`endif
);

  typedef struct packed {
    logic             regwrite;
    logic             memtoreg;
    logic             memwrite;
    logic             alusrc;
    logic             regdst;
    logic [ALUCW-1:0] alucontrol;
  } ctrl_t;

  ctrl_t dec_s;
  ctrl_t e_d;
  ctrl_t e_q;
  logic  branch_s;
  logic  jump_s;
  logic  regwrite_m_q;
  logic  memtoreg_m_q;
  logic  memwrite_m_q;
  logic  regwrite_w_q;
  logic  memtoreg_w_q;

  // Decode: unlisted encodings fall through to the all-zero bundle.
  always_comb begin
    dec_s    = '0;
    branch_s = 1'b0;
    jump_s   = 1'b0;
    case (opD)
      6'h00: begin
        case (functD)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: begin
            dec_s.regwrite   = 1'b1;
            dec_s.regdst     = 1'b1;
            dec_s.alucontrol = ALUCW'(functD);
          end
          default: dec_s = '0;
        endcase
      end
      6'h23: begin
        dec_s.regwrite   = 1'b1;
        dec_s.alusrc     = 1'b1;
        dec_s.memtoreg   = 1'b1;
        dec_s.alucontrol = ALUCW'(8'h20);
      end
      6'h2B: begin
        dec_s.memwrite   = 1'b1;
        dec_s.alusrc     = 1'b1;
        dec_s.alucontrol = ALUCW'(8'h20);
      end
      6'h04: begin
        branch_s         = 1'b1;
        dec_s.alucontrol = ALUCW'(8'h22);
      end
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin
        dec_s.regwrite = 1'b1;
        dec_s.alusrc   = 1'b1;
        case (opD)
          6'h0C:   dec_s.alucontrol = ALUCW'(8'h24);
          6'h0D:   dec_s.alucontrol = ALUCW'(8'h25);
          6'h0F:   dec_s.alucontrol = ALUCW'(8'h3C);
          default: dec_s.alucontrol = ALUCW'(8'h20);
        endcase
      end
      6'h02:   jump_s = 1'b1;
      default: dec_s  = '0;
    endcase
  end

  assign branchD = branch_s;
  assign jumpD   = jump_s;
  assign pcsrcD  = branch_s & equalD;

  // A flush replaces the instruction entering Execute with a bubble.
  always_comb begin
    e_d = '0;
    if (flushE) begin
      e_d = '0;
    end else begin
      e_d = dec_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q          <= '0;
      regwrite_m_q <= 1'b0;
      memtoreg_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
      regwrite_w_q <= 1'b0;
      memtoreg_w_q <= 1'b0;
    end else begin
      e_q          <= e_d;
      regwrite_m_q <= e_q.regwrite;
      memtoreg_m_q <= e_q.memtoreg;
      memwrite_m_q <= e_q.memwrite;
      regwrite_w_q <= regwrite_m_q;
      memtoreg_w_q <= memtoreg_m_q;
    end
  end

  assign regwriteE   = e_q.regwrite;
  assign memtoregE   = e_q.memtoreg;
  assign alusrcE     = e_q.alusrc;
  assign regdstE     = e_q.regdst;
  assign alucontrolE = e_q.alucontrol;
  assign regwriteM   = regwrite_m_q;
  assign memtoregM   = memtoreg_m_q;
  assign memwriteM   = memwrite_m_q;
  assign regwriteW   = regwrite_w_q;
  assign memtoregW   = memtoreg_w_q;

`ifdef PIPE_CTRL_ILLEGAL_EN
  logic illegal_d;
  logic illegal_q;

  function automatic logic is_illegal(input logic [5:0] op, input logic [5:0] fn);
    logic ill;
    ill = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: ill = 1'b0;
          default:                                  ill = 1'b1;
        endcase
      end
      6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h02: ill = 1'b0;
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

  // Sticky: only an illegal opcode that actually enters Execute sets the flag.
  always_comb begin
    illegal_d = illegal_q | (is_illegal(opD, functD) & ~flushE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegalF = illegal_q;
`endif

endmodule

// File: tb/tb_pipe_controller.sv
// Directed plus randomized check of pipe_controller against an independent decode model and a scoreboard queue.
// Builds with or without PIPE_CTRL_ILLEGAL_EN.
module tb_pipe_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opD;
  logic [5:0] functD;
  logic       equalD;
  logic       flushE;
  logic       pcsrcD, branchD, jumpD;
  logic       memtoregE, alusrcE, regdstE, regwriteE;
  logic [7:0] alucontrolE;
  logic       memtoregM, regwriteM, memwriteM;
  logic       memtoregW, regwriteW;
`ifdef PIPE_CTRL_ILLEGAL_EN
  logic       illegalF;
  logic       exp_ill;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic       mw;
    logic       as;
    logic       rd;
    logic [7:0] alu;
    logic       br;
    logic       jp;
    logic       ill;
  } dec_t;

  dec_t qe[$];
  dec_t exp_e;
  logic exp_m_rw, exp_m_m2r, exp_m_mw, exp_w_rw, exp_w_m2r;

  pipe_controller #(.ALUCW(8)) dut (
    .clk(clk), .rst(rst), .opD(opD), .functD(functD), .equalD(equalD), .flushE(flushE),
    .pcsrcD(pcsrcD), .branchD(branchD), .jumpD(jumpD),
    .memtoregE(memtoregE), .alusrcE(alusrcE), .regdstE(regdstE), .regwriteE(regwriteE),
    .alucontrolE(alucontrolE),
    .memtoregM(memtoregM), .regwriteM(regwriteM), .memwriteM(memwriteM),
    .memtoregW(memtoregW), .regwriteW(regwriteW)
`ifdef PIPE_CTRL_ILLEGAL_EN
    , .illegalF(illegalF)
`endif
  );

  always #5 clk = ~clk;

  function automatic dec_t model(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) begin
          d.rw = 1'b1; d.rd = 1'b1; d.alu = {2'b00, fn};
        end else if (fn != 6'h00) begin
          d.ill = 1'b1;
        end
      end
      6'h23: begin d.rw = 1'b1; d.as = 1'b1; d.m2r = 1'b1; d.alu = 8'h20; end
      6'h2B: begin d.mw = 1'b1; d.as = 1'b1; d.alu = 8'h20; end
      6'h04: begin d.br = 1'b1; d.alu = 8'h22; end
      6'h08: begin d.rw = 1'b1; d.as = 1'b1; d.alu = 8'h20; end
      6'h0C: begin d.rw = 1'b1; d.as = 1'b1; d.alu = 8'h24; end
      6'h0D: begin d.rw = 1'b1; d.as = 1'b1; d.alu = 8'h25; end
      6'h0F: begin d.rw = 1'b1; d.as = 1'b1; d.alu = 8'h3C; end
      6'h02: d.jp = 1'b1;
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string where);
    chk1({where, ".regwriteE"}, regwriteE, exp_e.rw);
    chk1({where, ".memtoregE"}, memtoregE, exp_e.m2r);
    chk1({where, ".alusrcE"}, alusrcE, exp_e.as);
    chk1({where, ".regdstE"}, regdstE, exp_e.rd);
    chk8({where, ".alucontrolE"}, alucontrolE, exp_e.alu);
    chk1({where, ".regwriteM"}, regwriteM, exp_m_rw);
    chk1({where, ".memtoregM"}, memtoregM, exp_m_m2r);
    chk1({where, ".memwriteM"}, memwriteM, exp_m_mw);
    chk1({where, ".regwriteW"}, regwriteW, exp_w_rw);
    chk1({where, ".memtoregW"}, memtoregW, exp_w_m2r);
`ifdef PIPE_CTRL_ILLEGAL_EN
    chk1({where, ".illegalF"}, illegalF, exp_ill);
`endif
  endtask

  task automatic clear_model();
    qe.delete();
    exp_e = '0;
    exp_m_rw = 1'b0; exp_m_m2r = 1'b0; exp_m_mw = 1'b0;
    exp_w_rw = 1'b0; exp_w_m2r = 1'b0;
`ifdef PIPE_CTRL_ILLEGAL_EN
    exp_ill = 1'b0;
`endif
  endtask

  // One Decode cycle: drive at negedge, check D outputs, push the expected E bundle, pop after the edge.
  task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic eq, input logic fl);
    dec_t d;
    @(negedge clk);
    opD = op; functD = fn; equalD = eq; flushE = fl;
    #1;
    d = model(op, fn);
    chk1({tag, ".branchD"}, branchD, d.br);
    chk1({tag, ".jumpD"}, jumpD, d.jp);
    chk1({tag, ".pcsrcD"}, pcsrcD, d.br & eq);
    qe.push_back(fl ? dec_t'('0) : d);
`ifdef PIPE_CTRL_ILLEGAL_EN
    exp_ill = exp_ill | (d.ill & ~fl);
`endif
    @(posedge clk);
    #1;
    exp_w_rw = exp_m_rw;  exp_w_m2r = exp_m_m2r;
    exp_m_rw = exp_e.rw;  exp_m_m2r = exp_e.m2r; exp_m_mw = exp_e.mw;
    if (qe.size() > 0) begin
      exp_e = qe.pop_front();
    end else begin
      chk1({tag, ".scoreboard_empty"}, 1'b1, 1'b0);
    end
    check_regs(tag);
  endtask

  // Reset asserted mid-cycle must clear registered outputs without a clock edge.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #2;
    opD = 6'h00; functD = 6'h00; equalD = 1'b0; flushE = 1'b0;
    rst = 1'b1;
    #1;
    clear_model();
    check_regs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [5:0] ops [12];
  logic [5:0] fns [7];

  initial begin
    ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h3F};
    rst = 1'b1; opD = 6'h04; functD = 6'h00; equalD = 1'b1; flushE = 1'b0;
    clear_model();
    #1;
    check_regs("reset");
    chk1("reset.pcsrcD_comb", pcsrcD, 1'b1);
    chk1("reset.branchD_comb", branchD, 1'b1);
    opD = 6'h00; equalD = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    step("ill_flushed", 6'h3F, 6'h00, 1'b0, 1'b1);
    step("lw", 6'h23, 6'h00, 1'b0, 1'b0);
    step("lw+1", 6'h00, 6'h00, 1'b0, 1'b0);
    step("lw+2", 6'h00, 6'h00, 1'b0, 1'b0);
    step("lw+3", 6'h00, 6'h00, 1'b0, 1'b0);
    step("beq_eq1", 6'h04, 6'h00, 1'b1, 1'b0);
    step("beq_eq0", 6'h04, 6'h00, 1'b0, 1'b0);
    step("sw_flush", 6'h2B, 6'h00, 1'b0, 1'b1);
    step("sw_flush+1", 6'h00, 6'h00, 1'b0, 1'b0);
    step("sw", 6'h2B, 6'h00, 1'b0, 1'b0);
    step("slt", 6'h00, 6'h2A, 1'b0, 1'b0);
    step("j", 6'h02, 6'h00, 1'b1, 1'b0);
    step("addi", 6'h08, 6'h11, 1'b0, 1'b0);
    step("andi", 6'h0C, 6'h00, 1'b0, 1'b0);
    step("ori", 6'h0D, 6'h00, 1'b0, 1'b0);
    step("lui", 6'h0F, 6'h00, 1'b0, 1'b0);
    step("add", 6'h00, 6'h20, 1'b0, 1'b0);
    step("sub", 6'h00, 6'h22, 1'b0, 1'b0);
    step("and", 6'h00, 6'h24, 1'b0, 1'b0);
    step("or", 6'h00, 6'h25, 1'b0, 1'b0);
    step("bad_funct_flushed", 6'h00, 6'h3F, 1'b0, 1'b1);
    step("ill_op", 6'h3F, 6'h00, 1'b0, 1'b0);
    step("after_ill_lw", 6'h23, 6'h00, 1'b0, 1'b0);
    step("after_ill_sw", 6'h2B, 6'h00, 1'b0, 1'b0);
    step("after_ill_add", 6'h00, 6'h20, 1'b0, 1'b0);
    mid_reset("mid_reset");
    step("refill1", 6'h00, 6'h00, 1'b0, 1'b0);
    step("refill2", 6'h23, 6'h00, 1'b0, 1'b0);
    step("refill3", 6'h2B, 6'h00, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [5:0] rop;
      logic [5:0] rfn;
      rop = ops[$urandom_range(0, 11)];
      rfn = fns[$urandom_range(0, 6)];
      step("random", rop, rfn, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_controller.md
# pipe_controller

Control unit for the five-stage pipelined MIPS core. Decodes `opD`/`functD` in Decode and produces the Decode-stage branch/jump controls. Carries the remaining control bits through its own D→E, E→M and M→W registers, so every stage of the datapath sees the controls of the instruction it holds. Honours the hazard unit's `flushE` by turning the instruction entering Execute into a bubble.

## Interface
Parameters:
- `ALUCW`, default 8: width of `alucontrolE`; fixed at 8 for this core.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opD`  in  6  instrD[31:26].
- `functD`  in  6  instrD[5:0].
- `equalD`  in  1  register comparator result from Decode (forwarded operands).
- `flushE`  in  1  bubble request for the D→E register, from the hazard unit.
- `pcsrcD`  out  1  take-branch select.
- `branchD`  out  1  instruction in Decode is `beq`.
- `jumpD`  out  1  instruction in Decode is `j`.
- `memtoregE`, `alusrcE`, `regdstE`, `regwriteE`  out  1 each  Execute controls.
- `alucontrolE`  out  ALUCW  ALU operation code.
- `memtoregM`, `regwriteM`, `memwriteM`  out  1 each  Memory controls.
- `memtoregW`, `regwriteW`  out  1 each  Writeback controls.
- `illegalF`  out  1  sticky illegal-instruction flag; exists only when the macro under Configuration is defined.

## Operation
Decode is combinational from `opD`/`functD`. Only `regwrite`, `memtoreg`, `memwrite`, `alusrc`, `regdst` and `alucontrol` are written; any bit not listed for an instruction is 0.
- R-type, op 0x00:
  - `regwrite=1`, `regdst=1`.
  - funct 0x20 add → alucontrol 0x20; 0x22 sub → 0x22; 0x24 and → 0x24; 0x25 or → 0x25; 0x2A slt → 0x2A.
  - funct 0x00 with the full word 0 is a NOP and decodes to all-zero controls.
- `lw` 0x23: `regwrite`, `alusrc`, `memtoreg`; alu 0x20.
- `sw` 0x2B: `memwrite`, `alusrc`; alu 0x20.
- `beq` 0x04: `branchD`; alu 0x22.
- `addi` 0x08: `regwrite`, `alusrc`; alu 0x20.
- `andi` 0x0C → 0x24, `ori` 0x0D → 0x25, `lui` 0x0F → 0x3C: each with `regwrite`, `alusrc`.
- `j` 0x02: `jumpD` only.
- Any other op, or an unlisted funct under op 0x00, is illegal and decodes to all-zero controls.
- `pcsrcD = branchD & equalD`, combinational, same cycle.

Pipeline registers:
- D→E register (regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol): loads the decoded bundle each edge. When `flushE`=1 it loads all zeros (synchronous clear).
- E→M register (regwrite, memtoreg, memwrite): loads each edge, no enable, no clear.
- M→W register (regwrite, memtoreg): loads each edge, no enable, no clear.
- `branchD`/`jumpD`/`pcsrcD` are not registered.
- Fetch/Decode stalls are the datapath's job; when Decode is stalled the hazard unit asserts `flushE`, so a stalled instruction never enters Execute twice.

## Timing
- Reset: asynchronous. While `rst`=1, every registered output is 0: `memtoregE`, `alusrcE`, `regdstE`, `regwriteE`, `alucontrolE`=0x00, `memtoregM`, `regwriteM`, `memwriteM`, `memtoregW`, `regwriteW`, `illegalF`.
- Combinational outputs (`branchD`, `jumpD`, `pcsrcD`) follow their inputs during reset as well.
- Latency: a control bit decoded in Decode in cycle n appears in E at n+1, M at n+2, W at n+3.
- `flushE` and a valid decode in the same cycle: flush wins, and E holds a bubble at n+1.
- Reset released mid-stream: the pipeline refills from zero bubbles. No spurious `regwrite` or `memwrite` in the first 3 cycles.

## Configuration
Macro `PIPE_CTRL_ILLEGAL_EN`.
- Defined:
  - Add a Decode-stage `illegalD` term.
  - Add port `illegalF`, set on the first edge where `illegalD`=1 and `flushE`=0. It stays set until `rst`.
  - The illegal instruction still travels down the pipe as all-zero controls.
- Undefined: no detection logic and no `illegalF` port. Illegal encodings silently decode to all-zero controls.

## Test plan
- Reset: assert `rst` mid-cycle → all registered outputs 0 immediately, with no clock edge needed.
- `lw` (op 0x23), `flushE`=0:
  - +1 cycle: `alusrcE`=1, `memtoregE`=1, `regwriteE`=1, `alucontrolE`=0x20.
  - +2 cycles: `regwriteM`=1, `memtoregM`=1.
  - +3 cycles: `regwriteW`=1, `memtoregW`=1.
- `beq` with `equalD`=1 → `pcsrcD`=1 and `branchD`=1 in the same cycle. With `equalD`=0 → `pcsrcD`=0. Next cycle: `alucontrolE`=0x22, `regwriteE`=0.
- `sw` with `flushE`=1 in the same cycle → next cycle all E outputs 0; two cycles later `memwriteM`=0.
- R-type funct 0x2A → `regdstE`=1, `alucontrolE`=0x2A. `j` → `jumpD`=1 and all E controls 0 next cycle.
- With `PIPE_CTRL_ILLEGAL_EN`:
  - op 0x3F → `illegalF`=1 after the edge, and it remains 1 through subsequent legal instructions until `rst`.
  - op 0x3F with `flushE`=1 → `illegalF` stays 0.
